// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, func_t and the
// decoded-instruction bundle handed to the operand stage.
package alu_pkg;

   typedef logic [3:0] func_t;

   localparam func_t RADD = 4'd0;
   localparam func_t RSUB = 4'd1;
   localparam func_t RMUL = 4'd2;
   localparam func_t RAND = 4'd3;
   localparam func_t ROR  = 4'd4;
   localparam func_t RXOR = 4'd5;
   localparam func_t RB   = 4'd6;

   localparam int N    = 8;
   localparam int NREG = 8;
   localparam int AW   = $clog2(NREG);

   typedef struct packed {
      func_t         func;
      logic [AW-1:0] rd;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [N-1:0]  imm;
      logic          use_imm;
      logic          wen;
   } instr_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Issue-side handshake, EX operand bus and debug read port
// of the ALU operand stage.
interface alu_operand_stage_if #(
   parameter int n    = 8,
   parameter int NREG = 8
);
   import alu_pkg::*;

   localparam int AW = $clog2(NREG);

   logic          hold;
   logic          in_valid;
   logic          in_ready;
   func_t         in_func;
   logic [AW-1:0] in_rd;
   logic [AW-1:0] in_rs;
   logic [AW-1:0] in_rt;
   logic [n-1:0]  in_imm;
   logic          in_use_imm;
   logic          in_wen;
   logic [n-1:0]  a;
   logic [n-1:0]  b;
   func_t         func;
   logic          ex_valid;
   logic [n-1:0]  result;
   logic [AW-1:0] dbg_addr;
   logic [n-1:0]  dbg_data;

   modport master (
      output hold, in_valid, in_func, in_rd, in_rs, in_rt,
      output in_imm, in_use_imm, in_wen, result, dbg_addr,
      input  in_ready, a, b, func, ex_valid, dbg_data
   );

   modport slave (
      input  hold, in_valid, in_func, in_rd, in_rs, in_rt,
      input  in_imm, in_use_imm, in_wen, result, dbg_addr,
      output in_ready, a, b, func, ex_valid, dbg_data
   );

endinterface

// File: rtl/alu.sv
// Combinational picoMIPS ALU fed by the operand stage.
// Products are truncated to n bits.
module alu
   import alu_pkg::*;
#(
   parameter int n = 8
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  func_t        func,
   output logic [n-1:0] result
);

   always_comb begin
      result = '0;
      case (func)
         RADD:    result = a + b;
         RSUB:    result = a - b;
         RMUL:    result = a * b;
         RAND:    result = a & b;
         ROR:     result = a | b;
         RXOR:    result = a ^ b;
         RB:      result = b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_operand_stage_regfile.sv
// NREG x n register file: two async read ports, one sync
// write port, a debug read port, r0 hardwired to zero.
module regfile #(
   parameter int n    = 8,
   parameter int NREG = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    we,
   input  logic [$clog2(NREG)-1:0] waddr,
   input  logic [n-1:0]            wdata,
   input  logic [$clog2(NREG)-1:0] addr_a,
   input  logic [$clog2(NREG)-1:0] addr_b,
   input  logic [$clog2(NREG)-1:0] dbg_addr,
   output logic [n-1:0]            data_a,
   output logic [n-1:0]            data_b,
   output logic [n-1:0]            dbg_data
);

   logic [n-1:0] mem [NREG];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we && waddr != '0) begin
         mem[waddr] <= wdata;
      end
   end

   assign data_a   = (addr_a == '0) ? '0 : mem[addr_a];
   assign data_b   = (addr_b == '0) ? '0 : mem[addr_b];
   assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue/operand stage ahead of the ALU: regfile read,
// single-level result forwarding and EX pipeline registers.
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int n    = 8,
   parameter int NREG = 8
) (
   input logic               clk,
   input logic               reset,
   alu_operand_stage_if.slave bus
);

   localparam int AW = $clog2(NREG);

   logic [AW-1:0] ex_rd;
   logic          ex_wen;
   logic [n-1:0]  rs_data;
   logic [n-1:0]  rt_data;
   logic [n-1:0]  a_fwd;
   logic [n-1:0]  b_fwd;
   logic          ex_live;
   logic          retire;

   regfile #(.n(n), .NREG(NREG)) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .we       (retire),
      .waddr    (ex_rd),
      .wdata    (bus.result),
      .addr_a   (bus.in_rs),
      .addr_b   (bus.in_rt),
      .dbg_addr (bus.dbg_addr),
      .data_a   (rs_data),
      .data_b   (rt_data),
      .dbg_data (bus.dbg_data)
   );

   assign bus.in_ready = !bus.hold;

   // Write-pending EX result that is also the live ALU output.
   assign ex_live = bus.ex_valid && ex_wen && ex_rd != '0;
   assign retire  = !bus.hold && ex_live;

   always_comb begin
      a_fwd = rs_data;
      b_fwd = rt_data;
      if (ex_live && ex_rd == bus.in_rs) a_fwd = bus.result;
      if (ex_live && ex_rd == bus.in_rt) b_fwd = bus.result;
      if (bus.in_use_imm) b_fwd = bus.in_imm;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.a        <= '0;
         bus.b        <= '0;
         bus.func     <= '0;
         bus.ex_valid <= 1'b0;
         ex_rd        <= '0;
         ex_wen       <= 1'b0;
      end else if (!bus.hold) begin
         bus.ex_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.a    <= a_fwd;
            bus.b    <= b_fwd;
            bus.func <= bus.in_func;
            ex_rd    <= bus.in_rd;
            ex_wen   <= bus.in_wen;
         end
      end
   end

endmodule
